// File: rtl/oled_pkg.sv
// SSD1306 command constants, glyph-select names and the glyph-width decode
// shared by the glyph scheduler and the display-content logic.
package oled_pkg;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COLL_BASE = 8'h00;
  localparam logic [7:0] CMD_COLH_BASE = 8'h10;

  typedef enum logic [5:0] {
    GLYPH_F    = 6'd0,
    GLYPH_G    = 6'd1,
    GLYPH_P    = 6'd2,
    GLYPH_A    = 6'd3,
    GLYPH_ZHI  = 6'd4,
    GLYPH_LV   = 6'd5,
    GLYPH_WEN  = 6'd6,
    GLYPH_DU   = 6'd7,
    GLYPH_SHI  = 6'd8,
    GLYPH_DU2  = 6'd9,
    GLYPH_DOT  = 6'd10,
    GLYPH_DEGC = 6'd11,
    GLYPH_LB   = 6'd12,
    GLYPH_LP   = 6'd13,
    GLYPH_LM   = 6'd14
  } glyph_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMD_PAGE = 4'd1,
    ST_CMD_COLL = 4'd2,
    ST_CMD_COLH = 4'd3,
    ST_FETCH    = 4'd4,
    ST_WAIT_ROM = 4'd5,
    ST_SEND     = 4'd6,
    ST_NEXT_ROW = 4'd7,
    ST_FINISH   = 4'd8
  } sched_state_e;

  // CJK glyphs and the degree-C sign are double width
  function automatic logic [4:0] glyph_width(input logic [5:0] glyph);
    logic [4:0] width;
    case (glyph)
      GLYPH_ZHI, GLYPH_LV, GLYPH_WEN, GLYPH_DU,
      GLYPH_SHI, GLYPH_DU2, GLYPH_DEGC: width = 5'd16;
      default:                          width = 5'd8;
    endcase
    return width;
  endfunction

endpackage

// File: rtl/oled_glyph_scheduler.sv
// Draws one 16-pixel-tall glyph: page/column commands, then font ROM column
// bytes for the top half, then the same for the bottom half on the next page.
module oled_glyph_scheduler
  import oled_pkg::*;
#(
  parameter int ROM_LAT    = 1,
  parameter int NUM_GLYPHS = 15
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_glyph,
  input  logic [2:0] req_page,
  input  logic [6:0] req_col,
  output logic [5:0] font_sel,
  output logic       font_row,
  output logic [8:0] index,
  input  logic [7:0] font_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic       wr_dc,
  output logic [7:0] wr_byte,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [5:0] GLYPH_LIMIT = 6'(NUM_GLYPHS);
  localparam logic [7:0] WAIT_LAST   = 8'(ROM_LAT - 1);

  sched_state_e state_r, state_s;
  logic [5:0] glyph_r, glyph_s;
  logic [2:0] page_r, page_s, page_cur_r, page_cur_s;
  logic [6:0] col_r, col_s;
  logic [3:0] col_cnt_r, col_cnt_s, last_col_s;
  logic [7:0] wait_cnt_r, wait_cnt_s;
  logic       req_ready_r, req_ready_s, wr_valid_r, wr_valid_s, wr_dc_r, wr_dc_s;
  logic [7:0] wr_byte_r, wr_byte_s;
  logic [5:0] font_sel_r, font_sel_s;
  logic       font_row_r, font_row_s;
  logic [8:0] index_r, index_s;
  logic       busy_r, busy_s, done_r, done_s, err_r, err_s;

  assign last_col_s = 4'(glyph_width(glyph_r) - 5'd1);

  // State register and registered outputs
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      glyph_r     <= 6'd0;
      page_r      <= 3'd0;
      page_cur_r  <= 3'd0;
      col_r       <= 7'd0;
      col_cnt_r   <= 4'd0;
      wait_cnt_r  <= 8'd0;
      req_ready_r <= 1'b1;
      wr_valid_r  <= 1'b0;
      wr_dc_r     <= 1'b0;
      wr_byte_r   <= 8'd0;
      font_sel_r  <= 6'd0;
      font_row_r  <= 1'b0;
      index_r     <= 9'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      glyph_r     <= glyph_s;
      page_r      <= page_s;
      page_cur_r  <= page_cur_s;
      col_r       <= col_s;
      col_cnt_r   <= col_cnt_s;
      wait_cnt_r  <= wait_cnt_s;
      req_ready_r <= req_ready_s;
      wr_valid_r  <= wr_valid_s;
      wr_dc_r     <= wr_dc_s;
      wr_byte_r   <= wr_byte_s;
      font_sel_r  <= font_sel_s;
      font_row_r  <= font_row_s;
      index_r     <= index_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  // Next-state and next-output decode; holding by default keeps the link stable under backpressure
  always_comb begin
    state_s     = state_r;
    glyph_s     = glyph_r;
    page_s      = page_r;
    page_cur_s  = page_cur_r;
    col_s       = col_r;
    col_cnt_s   = col_cnt_r;
    wait_cnt_s  = wait_cnt_r;
    req_ready_s = req_ready_r;
    wr_valid_s  = wr_valid_r;
    wr_dc_s     = wr_dc_r;
    wr_byte_s   = wr_byte_r;
    font_sel_s  = font_sel_r;
    font_row_s  = font_row_r;
    index_s     = index_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          if (req_glyph >= GLYPH_LIMIT) begin
            err_s = 1'b1;
          end else begin
            glyph_s     = req_glyph;
            page_s      = req_page;
            page_cur_s  = req_page;
            col_s       = req_col;
            col_cnt_s   = 4'd0;
            font_sel_s  = req_glyph;
            font_row_s  = 1'b0;
            index_s     = 9'd0;
            req_ready_s = 1'b0;
            busy_s      = 1'b1;
            wr_valid_s  = 1'b1;
            wr_dc_s     = 1'b0;
            wr_byte_s   = CMD_PAGE_BASE | {5'd0, req_page};
            state_s     = ST_CMD_PAGE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMD_PAGE: begin
        if (wr_valid_r && wr_ready) begin
          wr_byte_s = CMD_COLL_BASE | {4'd0, col_r[3:0]};
          state_s   = ST_CMD_COLL;
        end else begin
          state_s = ST_CMD_PAGE;
        end
      end
      ST_CMD_COLL: begin
        if (wr_valid_r && wr_ready) begin
          wr_byte_s = CMD_COLH_BASE | {5'd0, col_r[6:4]};
          state_s   = ST_CMD_COLH;
        end else begin
          state_s = ST_CMD_COLL;
        end
      end
      ST_CMD_COLH: begin
        if (wr_valid_r && wr_ready) begin
          wr_valid_s = 1'b0;
          index_s    = {5'd0, col_cnt_r};
          state_s    = ST_FETCH;
        end else begin
          state_s = ST_CMD_COLH;
        end
      end
      ST_FETCH: begin
        wait_cnt_s = 8'd0;
        state_s    = ST_WAIT_ROM;
      end
      ST_WAIT_ROM: begin
        if (wait_cnt_r == WAIT_LAST) begin
          wr_valid_s = 1'b1;
          wr_dc_s    = 1'b1;
          wr_byte_s  = font_data;
          state_s    = ST_SEND;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      ST_SEND: begin
        if (wr_valid_r && wr_ready) begin
          wr_valid_s = 1'b0;
          if (col_cnt_r != last_col_s) begin
            col_cnt_s = col_cnt_r + 4'd1;
            index_s   = {5'd0, 4'(col_cnt_r + 4'd1)};
            state_s   = ST_FETCH;
          end else if (!font_row_r) begin
            font_row_s = 1'b1;
            page_cur_s = page_r + 3'd1;
            col_cnt_s  = 4'd0;
            index_s    = 9'd0;
            state_s    = ST_NEXT_ROW;
          end else begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_FINISH;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_NEXT_ROW: begin
        wr_valid_s = 1'b1;
        wr_dc_s    = 1'b0;
        wr_byte_s  = CMD_PAGE_BASE | {5'd0, page_cur_r};
        state_s    = ST_CMD_PAGE;
      end
      ST_FINISH: begin
        req_ready_s = 1'b1;
        state_s     = ST_IDLE;
      end
      default: begin
        req_ready_s = 1'b1;
        busy_s      = 1'b0;
        wr_valid_s  = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  assign req_ready = req_ready_r;
  assign font_sel  = font_sel_r;
  assign font_row  = font_row_r;
  assign index     = index_r;
  assign wr_valid  = wr_valid_r;
  assign wr_dc     = wr_dc_r;
  assign wr_byte   = wr_byte_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_oled_glyph_scheduler.sv
// Directed bench for oled_glyph_scheduler with a registered font ROM model
// and a capture queue of every byte the link writer accepts.
module tb_oled_glyph_scheduler;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [5:0] req_glyph = 6'd0;
  logic [2:0] req_page = 3'd0;
  logic [6:0] req_col = 7'd0;
  logic [5:0] font_sel;
  logic       font_row;
  logic [8:0] index;
  logic [7:0] font_data = 8'd0;
  logic       wr_valid;
  logic       wr_ready = 1'b1;
  logic       wr_dc;
  logic [7:0] wr_byte;
  logic       busy, done, err;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [8:0] cap_q[$];
  logic [8:0] exp_q[$];

  oled_glyph_scheduler #(.ROM_LAT(1), .NUM_GLYPHS(15)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_glyph(req_glyph), .req_page(req_page), .req_col(req_col),
    .font_sel(font_sel), .font_row(font_row), .index(index), .font_data(font_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dc(wr_dc), .wr_byte(wr_byte),
    .busy(busy), .done(done), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] rom_byte(input logic [5:0] g, input logic r, input logic [3:0] i);
    logic [7:0] g0t [8];
    logic [7:0] g0b [8];
    logic [7:0] g6t [4];
    logic [7:0] g6b [4];
    logic [7:0] b;
    g0t = '{8'h08, 8'hF8, 8'h88, 8'h88, 8'hE8, 8'h08, 8'h10, 8'h00};
    g0b = '{8'h20, 8'h3F, 8'h20, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    g6t = '{8'h10, 8'h60, 8'h02, 8'h8C};
    g6b = '{8'h04, 8'h04, 8'h7E, 8'h01};
    if (g == 6'd0 && i < 4'd8)      b = r ? g0b[i[2:0]] : g0t[i[2:0]];
    else if (g == 6'd6 && i < 4'd4) b = r ? g6b[i[1:0]] : g6t[i[1:0]];
    else                            b = {g[2:0], r, i} ^ 8'h3C;
    return b;
  endfunction

  // Font ROM: registered one-cycle read
  always @(posedge sys_clk) font_data <= rom_byte(font_sel, font_row, index[3:0]);

  // Capture accepted bytes and count pulses
  always @(posedge sys_clk) begin
    if (!rst && wr_valid && wr_ready) cap_q.push_back({wr_dc, wr_byte});
    if (!rst && done) done_cnt <= done_cnt + 1;
    if (!rst && err) err_cnt <= err_cnt + 1;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_exp(input logic [5:0] g, input logic [2:0] pg, input logic [6:0] col);
    int w;
    logic [2:0] p;
    w = ((g >= 6'd4 && g <= 6'd9) || g == 6'd11) ? 16 : 8;
    for (int r = 0; r < 2; r++) begin
      p = pg + 3'(r);
      exp_q.push_back({1'b0, 8'hB0 | {5'd0, p}});
      exp_q.push_back({1'b0, {4'd0, col[3:0]}});
      exp_q.push_back({1'b0, 8'h10 | {5'd0, col[6:4]}});
      for (int i = 0; i < w; i++) exp_q.push_back({1'b1, rom_byte(g, 1'(r), 4'(i))});
    end
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), {23'd0, cap_q[i]}, {23'd0, exp_q[i]});
  endtask

  task automatic issue(input logic [5:0] g, input logic [2:0] pg, input logic [6:0] col,
                       input bit keep, input string tag);
    req_glyph = g; req_page = pg; req_col = col; req_valid = 1'b1;
    for (int i = 0; i < 400 && !req_ready; i++) tick();
    check({tag, "_accept"}, {31'd0, req_ready}, 32'd1);
    tick();
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 400 && done_cnt < target; i++) tick();
    check({tag, "_done"}, 32'(done_cnt), 32'(target));
  endtask

  task automatic spot(input string tag, input int idx, input logic [8:0] v);
    check(tag, {23'd0, (idx < cap_q.size()) ? cap_q[idx] : 9'h1FF}, {23'd0, v});
  endtask

  initial begin
    int base;
    bit low_ok;

    // Reset state
    tick(); tick();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_wr", {22'd0, wr_valid, wr_dc, wr_byte}, 32'd0);
    check("rst_font", {16'd0, font_sel, font_row, index}, 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: glyph 0, page 2, col 0x25
    cap_q.delete(); exp_q.delete();
    build_exp(6'd0, 3'd2, 7'h25);
    issue(6'd0, 3'd2, 7'h25, 1'b0, "s1");
    check("s1_busy", {30'd0, busy, req_ready}, 32'd2);
    wait_done(1, "s1");
    cmp_stream("s1");
    spot("s1_b2", 0, 9'h0B2);
    spot("s1_first", 3, 9'h108);
    spot("s1_b3", 11, 9'h0B3);
    spot("s1_bot0", 14, 9'h120);
    tick();
    check("s1_single_done", 32'(done_cnt), 32'd1);

    // 2: glyph 6, page 7 (wraps to 0), col 0x64
    cap_q.delete(); exp_q.delete();
    build_exp(6'd6, 3'd7, 7'h64);
    issue(6'd6, 3'd7, 7'h64, 1'b0, "s2");
    wait_done(2, "s2");
    cmp_stream("s2");
    spot("s2_b7", 0, 9'h0B7);
    spot("s2_coll", 1, 9'h004);
    spot("s2_colh", 2, 9'h016);
    spot("s2_d3", 6, 9'h18C);
    spot("s2_wrap", 19, 9'h0B0);
    spot("s2_bot2", 24, 9'h17E);

    // 3: backpressure on the third data byte
    cap_q.delete(); exp_q.delete();
    build_exp(6'd0, 3'd2, 7'h25);
    issue(6'd0, 3'd2, 7'h25, 1'b0, "s3");
    for (int i = 0; i < 100 && !(wr_valid && wr_dc && cap_q.size() == 5); i++) tick();
    check("s3_reach", {31'd0, wr_valid}, 32'd1);
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("s3_hold%0d", i), {22'd0, wr_valid, wr_dc, wr_byte}, 32'h388);
    end
    wr_ready = 1'b1;
    wait_done(3, "s3");
    cmp_stream("s3");

    // 4: invalid glyph is dropped
    cap_q.delete();
    base = err_cnt;
    req_glyph = 6'd20; req_page = 3'd1; req_col = 7'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("s4_err", {29'd0, err, wr_valid, req_ready}, 32'h5);
    tick();
    check("s4_after", {29'd0, err, busy, req_ready}, 32'h1);
    tick(); tick();
    check("s4_err_once", 32'(err_cnt - base), 32'd1);
    check("s4_no_write", 32'(cap_q.size()), 32'd0);

    // 5: reset mid-stream of glyph 6, then a clean draw with column overflow
    cap_q.delete();
    base = done_cnt;
    issue(6'd6, 3'd7, 7'h64, 1'b0, "s5");
    for (int i = 0; i < 200 && cap_q.size() < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_abort", {28'd0, wr_valid, busy, done, req_ready}, 32'h1);
    tick(); tick();
    check("s5_no_done", 32'(done_cnt), 32'(base));
    cap_q.delete(); exp_q.delete();
    build_exp(6'd2, 3'd0, 7'h7C);
    issue(6'd2, 3'd0, 7'h7C, 1'b0, "s5b");
    wait_done(base + 1, "s5b");
    cmp_stream("s5b");

    // 6: back-to-back requests held valid
    cap_q.delete(); exp_q.delete();
    base = done_cnt;
    build_exp(6'd3, 3'd4, 7'h10);
    build_exp(6'd11, 3'd5, 7'h30);
    issue(6'd3, 3'd4, 7'h10, 1'b1, "s6a");
    req_glyph = 6'd11; req_page = 3'd5; req_col = 7'h30;
    low_ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (done_cnt > base) break;
      if (req_ready !== 1'b0) low_ok = 1'b0;
      tick();
    end
    check("s6_ready_low", {31'd0, low_ok}, 32'd1);
    check("s6_first_done", 32'(done_cnt), 32'(base + 1));
    check("s6_ready_after", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("s6_second_busy", {31'd0, busy}, 32'd1);
    wait_done(base + 2, "s6b");
    cmp_stream("s6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
